pipe_hazard_regs: RTL and testbench
===================================

// Module: pipe_hazard_regs
// PURPOSE
//  Stall/flush consumer for the hazard unit: PC register, IF/ID and ID/EX pipeline registers of the 5-stage MIPS.
//  Applies stallF/stallD/flushD/flushE plus branch/jump redirect; inserts bubbles and tracks per-stage valid bits.
//  Sits between instruction memory/fetch and the execute stage; stall/flush inputs come from the hazard unit.
// PARAMETERS
//  DATA_W    32            datapath width (PC, instruction, operands)
//  CTRL_W    8             packed ID/EX control bus width; bit0=RegWrite, bit1=MemtoReg, bit2=MemWrite
//  RESET_PC  32'h0000_0000 PC value after reset
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       asynchronous, active-high reset
//  stallF         in   1       hold PC
//  stallD         in   1       hold IF/ID
//  flushD         in   1       clear IF/ID (jump)
//  flushE         in   1       clear ID/EX (bubble)
//  pcsrcD         in   1       branch taken, resolved in decode
//  jumpD          in   1       jump in decode
//  branch_targetD in   DATA_W  branch target
//  jump_targetD   in   DATA_W  jump target
//  instrF         in   DATA_W  fetched instruction
//  pcF            out  DATA_W  current PC
//  pcplus4F       out  DATA_W  pcF+4, combinational
//  instrD         out  DATA_W  IF/ID instruction
//  pcplus4D       out  DATA_W  IF/ID PC+4
//  validD         out  1       IF/ID holds a real instruction
//  ctrlD          in   CTRL_W  decoded control
//  rd1D, rd2D     in   DATA_W  register operands
//  signimmD       in   DATA_W  sign-extended immediate
//  rsD,rtD,rdD    in   5       register specifiers
//  ctrlE          out  CTRL_W  ID/EX control
//  rd1E, rd2E     out  DATA_W  ID/EX operands
//  signimmE       out  DATA_W  ID/EX immediate
//  rsE,rtE,rdE    out  5       ID/EX specifiers
//  validE         out  1       ID/EX holds a real instruction
// BEHAVIOUR
//  Reset (asynchronous, takes effect immediately, also mid-stall): pcF=RESET_PC; all IF/ID and ID/EX fields 0;
//    validD=validE=0. First clk edge after release loads IF/ID from instrF; validD=1.
//  PC update each edge, priority order: stallF -> hold; jumpD -> jump_targetD; pcsrcD -> branch_targetD;
//    else pcplus4F. Redirects arriving while stallF=1 are dropped. The hazard unit re-presents them next cycle.
//  pcplus4F wraps modulo 2^DATA_W (32'hFFFF_FFFC -> 0).
//  IF/ID, priority order: stallD -> hold all fields incl. validD; clear -> instrD=0 (nop), pcplus4D=0, validD=0;
//    else load instrF/pcplus4F, validD=1. clear = flushD | pcsrcD. Stall beats flush, so a stalled jump/branch
//    stays in decode and flushes on the cycle it proceeds.
//  ID/EX, no stall input: flushE -> all fields 0, validE=0 (ctrlE=0 guarantees no RegWrite/MemWrite);
//    else load decode inputs, validE=validD.
//  Latency: instruction moves F->D->E in 1 cycle per stage when unstalled. Load-use stall costs 1 bubble in E.
//  Simultaneous stallD=1 & flushE=1: D held, E gets bubble.
//  stallF=0 with stallD=1 is illegal. No checking in RTL; the bench asserts it.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds outputs stall_cnt[31:0] (edges with stallD=1) and bubble_cnt[31:0]
//    (edges with flushE=1 or IF/ID clear). Both reset to 0 and saturate at 32'hFFFF_FFFF.
//  Not defined: those ports and registers do not exist. All other behaviour is identical.
// TESTING
//  Reset: rst=1 mid-run -> pcF=0, validD=validE=0, ctrlE=0 immediately, before any clk edge.
//  Sequential: instrF fed 3 words, no hazards -> pcF 0,4,8,C; instrD follows 1 cycle later, ctrlE 2 later.
//  Load-use: stallF=stallD=flushE=1 for 1 cycle -> pcF and instrD held, validE=0/ctrlE=0 once, then resume.
//  Jump: jumpD=1, flushD=1, jump_targetD=32'h40 -> pcF=32'h40, instrD=0, validD=0 next cycle.
//  Branch stall then taken: stallF/D=1 with pcsrcD=1 -> PC held; next cycle pcsrcD=1, stalls 0 -> pcF=branch_targetD.
//  Perf (HAZARD_PERF_CNT_EN): 5 stall cycles + 2 flushE -> stall_cnt=5, bubble_cnt>=2; forced saturation holds.

Source files
------------

// File: rtl/pipe_hazard_regs.sv
// ---------------------------------------------------------------------------
// PipeHazardRegs (top module pipe_hazard_regs)
//
// Purpose:
//   Front-end state of the 5-stage MIPS pipeline that follows the hazard
//   unit's orders. It holds the PC register, the IF/ID pipeline register and
//   the ID/EX pipeline register. It applies stallF/stallD/flushD/flushE and
//   the decode-stage branch/jump redirect. It inserts bubbles and tracks a
//   valid bit for each stage.
//
// Ports:
//   clk, rst                       rising-edge clock, async active-high reset
//   stallF, stallD                 hold PC / hold IF/ID
//   flushD, flushE                 clear IF/ID / insert bubble into ID/EX
//   pcsrcD, jumpD                  taken branch / jump resolved in decode
//   branch_targetD, jump_targetD   redirect targets
//   instrF                         fetched instruction
//   pcF, pcplus4F                  current PC and PC+4 (combinational)
//   instrD, pcplus4D, validD       IF/ID contents
//   ctrlD, rd1D, rd2D, signimmD,
//   rsD, rtD, rdD                  decode-stage values headed for execute
//   ctrlE, rd1E, rd2E, signimmE,
//   rsE, rtE, rdE, validE          ID/EX contents
//
// Optional feature (macro HAZARD_PERF_CNT_EN):
//   When the macro is defined, the module adds the outputs stall_cnt and
//   bubble_cnt. Both are saturating 32-bit event counters. When the macro is
//   undefined, these ports and their registers do not exist.
// ---------------------------------------------------------------------------
module pipe_hazard_regs #(
    parameter int                 DATA_W   = 32,
    parameter int                 CTRL_W   = 8,
    parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallF,
    input  logic              stallD,
    input  logic              flushD,
    input  logic              flushE,
    input  logic              pcsrcD,
    input  logic              jumpD,
    input  logic [DATA_W-1:0] branch_targetD,
    input  logic [DATA_W-1:0] jump_targetD,
    input  logic [DATA_W-1:0] instrF,
    output logic [DATA_W-1:0] pcF,
    output logic [DATA_W-1:0] pcplus4F,
    output logic [DATA_W-1:0] instrD,
    output logic [DATA_W-1:0] pcplus4D,
    output logic              validD,
    input  logic [CTRL_W-1:0] ctrlD,
    input  logic [DATA_W-1:0] rd1D,
    input  logic [DATA_W-1:0] rd2D,
    input  logic [DATA_W-1:0] signimmD,
    input  logic [4:0]        rsD,
    input  logic [4:0]        rtD,
    input  logic [4:0]        rdD,
    output logic [CTRL_W-1:0] ctrlE,
    output logic [DATA_W-1:0] rd1E,
    output logic [DATA_W-1:0] rd2E,
    output logic [DATA_W-1:0] signimmE,
    output logic [4:0]        rsE,
    output logic [4:0]        rtE,
    output logic [4:0]        rdE,
`ifdef HAZARD_PERF_CNT_EN
    output logic              validE,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`else
    output logic              validE
`endif
);

    logic [DATA_W-1:0] pcNext;
    logic              clearD;

    // The adder has no carry out, so PC+4 wraps modulo 2^DATA_W.
    assign pcplus4F = pcF + DATA_W'(4);

    // A taken branch in decode squashes the wrong-path fetch, the same way a
    // jump flush does.
    assign clearD = flushD | pcsrcD;

    // Next-PC select. A jump wins over a branch. While stallF is high, any
    // redirect is dropped, and the hazard unit presents it again on a later
    // cycle.
    always_comb begin
        pcNext = pcplus4F;
        if (stallF)
            pcNext = pcF;
        else if (jumpD)
            pcNext = jump_targetD;
        else if (pcsrcD)
            pcNext = branch_targetD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pcF <= RESET_PC;
        else
            pcF <= pcNext;
    end

    // IF/ID register. Stall has priority over clear, so a stalled jump or
    // branch stays in decode and flushes on the cycle it proceeds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instrD   <= '0;
            pcplus4D <= '0;
            validD   <= 1'b0;
        end else if (stallD) begin
            instrD   <= instrD;
            pcplus4D <= pcplus4D;
            validD   <= validD;
        end else if (clearD) begin
            instrD   <= '0;
            pcplus4D <= '0;
            validD   <= 1'b0;
        end else begin
            instrD   <= instrF;
            pcplus4D <= pcplus4F;
            validD   <= 1'b1;
        end
    end

    // ID/EX register. This register never holds. A flush loads an all-zero
    // bubble, and ctrlE = 0 guarantees that the bubble never writes the
    // register file or memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flushE) begin
            ctrlE    <= '0;
            rd1E     <= '0;
            rd2E     <= '0;
            signimmE <= '0;
            rsE      <= '0;
            rtE      <= '0;
            rdE      <= '0;
            validE   <= 1'b0;
        end else begin
            ctrlE    <= ctrlD;
            rd1E     <= rd1D;
            rd2E     <= rd2D;
            signimmE <= signimmD;
            rsE      <= rsD;
            rtE      <= rtD;
            rdE      <= rdD;
            validE   <= validD;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // A bubble is counted when execute is flushed or when decode is actually
    // cleared. A clear request is not counted while stallD holds decode.
    logic bubbleEvent;
    assign bubbleEvent = flushE | (clearD & ~stallD);

    // Saturating event counters. They stop at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stallD && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
            if (bubbleEvent && (bubble_cnt != 32'hFFFF_FFFF))
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_regs.sv
// ---------------------------------------------------------------------------
// Testbench for pipe_hazard_regs. Each scenario task drives directed vectors
// and compares the outputs against hand-computed values. The bench samples
// outputs 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallF, stallD, flushD, flushE, pcsrcD, jumpD;
    logic [31:0] branch_targetD, jump_targetD, instrF;
    logic [31:0] pcF, pcplus4F, instrD, pcplus4D;
    logic        validD, validE;
    logic [7:0]  ctrlD, ctrlE;
    logic [31:0] rd1D, rd2D, signimmD, rd1E, rd2E, signimmE;
    logic [4:0]  rsD, rtD, rdD, rsE, rtE, rdE;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, bubble_cnt;
`endif

    int checkCnt = 0;
    int passCnt  = 0;

    always #5 clk = ~clk;

    pipe_hazard_regs dut (
        .clk(clk), .rst(rst),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .pcsrcD(pcsrcD), .jumpD(jumpD),
        .branch_targetD(branch_targetD), .jump_targetD(jump_targetD),
        .instrF(instrF), .pcF(pcF), .pcplus4F(pcplus4F),
        .instrD(instrD), .pcplus4D(pcplus4D), .validD(validD),
        .ctrlD(ctrlD), .rd1D(rd1D), .rd2D(rd2D), .signimmD(signimmD),
        .rsD(rsD), .rtD(rtD), .rdD(rdD),
        .ctrlE(ctrlE), .rd1E(rd1E), .rd2E(rd2E), .signimmE(signimmE),
        .rsE(rsE), .rtE(rtE), .rdE(rdE),
`ifdef HAZARD_PERF_CNT_EN
        .validE(validE), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`else
        .validE(validE)
`endif
    );

    // The hazard unit must never hold decode while fetch advances.
    always @(posedge clk) begin
        if (!rst)
            assert (!(stallD && !stallF)) else $error("[TB] illegal stallD=1 with stallF=0");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stallF = 0; stallD = 0; flushD = 0; flushE = 0; pcsrcD = 0; jumpD = 0;
        branch_targetD = 0; jump_targetD = 0; instrF = 32'hDEAD_0001;
        ctrlD = 8'h5A; rd1D = 32'h11; rd2D = 32'h22; signimmD = 32'h33;
        rsD = 5'd1; rtD = 5'd2; rdD = 5'd3;
        step(); step();
        checkCnt++; if (pcF !== 32'h0) $display("[TB] FAIL rst_pc got %h want %h", pcF, 32'h0); else passCnt++;
        checkCnt++; if (validD !== 1'b0) $display("[TB] FAIL rst_validD got %b want 0", validD); else passCnt++;
        checkCnt++; if (ctrlE !== 8'h0) $display("[TB] FAIL rst_ctrlE got %h want 00", ctrlE); else passCnt++;
        rst = 1'b0;
        step(); step();
        checkCnt++; if (validE !== 1'b1) $display("[TB] FAIL pre_validE got %b want 1", validE); else passCnt++;
        checkCnt++; if (ctrlE !== 8'h5A) $display("[TB] FAIL pre_ctrlE got %h want 5a", ctrlE); else passCnt++;
        // Assert reset mid-cycle. The outputs must clear without a clock edge.
        #2 rst = 1'b1;
        #1;
        checkCnt++; if (pcF !== 32'h0) $display("[TB] FAIL midrst_pc got %h want 0", pcF); else passCnt++;
        checkCnt++; if (validD !== 1'b0) $display("[TB] FAIL midrst_validD got %b want 0", validD); else passCnt++;
        checkCnt++; if (validE !== 1'b0) $display("[TB] FAIL midrst_validE got %b want 0", validE); else passCnt++;
        checkCnt++; if (ctrlE !== 8'h0) $display("[TB] FAIL midrst_ctrlE got %h want 00", ctrlE); else passCnt++;
        checkCnt++; if (instrD !== 32'h0) $display("[TB] FAIL midrst_instrD got %h want 0", instrD); else passCnt++;
        step();
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        instrF = 32'hA000_0000; ctrlD = 8'h00;
        step();
        checkCnt++; if (pcF !== 32'h4) $display("[TB] FAIL seq_pc1 got %h want 4", pcF); else passCnt++;
        checkCnt++; if (instrD !== 32'hA000_0000) $display("[TB] FAIL seq_instrD1 got %h want a0000000", instrD); else passCnt++;
        checkCnt++; if (validD !== 1'b1) $display("[TB] FAIL seq_validD1 got %b want 1", validD); else passCnt++;
        checkCnt++; if (pcplus4D !== 32'h4) $display("[TB] FAIL seq_pc4D1 got %h want 4", pcplus4D); else passCnt++;
        instrF = 32'hA000_0001; ctrlD = 8'h11;
        step();
        checkCnt++; if (pcF !== 32'h8) $display("[TB] FAIL seq_pc2 got %h want 8", pcF); else passCnt++;
        checkCnt++; if (instrD !== 32'hA000_0001) $display("[TB] FAIL seq_instrD2 got %h want a0000001", instrD); else passCnt++;
        checkCnt++; if (ctrlE !== 8'h11) $display("[TB] FAIL seq_ctrlE2 got %h want 11", ctrlE); else passCnt++;
        checkCnt++; if (validE !== 1'b1) $display("[TB] FAIL seq_validE2 got %b want 1", validE); else passCnt++;
        instrF = 32'hA000_0002; ctrlD = 8'h22;
        step();
        checkCnt++; if (pcF !== 32'hC) $display("[TB] FAIL seq_pc3 got %h want c", pcF); else passCnt++;
        checkCnt++; if (instrD !== 32'hA000_0002) $display("[TB] FAIL seq_instrD3 got %h want a0000002", instrD); else passCnt++;
        checkCnt++; if (ctrlE !== 8'h22) $display("[TB] FAIL seq_ctrlE3 got %h want 22", ctrlE); else passCnt++;
    endtask

    task automatic test_load_use();
        instrF = 32'hA000_0003; ctrlD = 8'h33; rd1D = 32'h5; rdD = 5'd9;
        stallF = 1; stallD = 1; flushE = 1;
        step();
        checkCnt++; if (pcF !== 32'hC) $display("[TB] FAIL lu_pc_hold got %h want c", pcF); else passCnt++;
        checkCnt++; if (instrD !== 32'hA000_0002) $display("[TB] FAIL lu_instrD_hold got %h want a0000002", instrD); else passCnt++;
        checkCnt++; if (validD !== 1'b1) $display("[TB] FAIL lu_validD got %b want 1", validD); else passCnt++;
        checkCnt++; if (validE !== 1'b0) $display("[TB] FAIL lu_validE got %b want 0", validE); else passCnt++;
        checkCnt++; if (ctrlE !== 8'h0) $display("[TB] FAIL lu_ctrlE got %h want 00", ctrlE); else passCnt++;
        checkCnt++; if (rd1E !== 32'h0) $display("[TB] FAIL lu_rd1E got %h want 0", rd1E); else passCnt++;
        stallF = 0; stallD = 0; flushE = 0;
        step();
        checkCnt++; if (pcF !== 32'h10) $display("[TB] FAIL lu_pc_resume got %h want 10", pcF); else passCnt++;
        checkCnt++; if (instrD !== 32'hA000_0003) $display("[TB] FAIL lu_instrD_resume got %h want a0000003", instrD); else passCnt++;
        checkCnt++; if (ctrlE !== 8'h33) $display("[TB] FAIL lu_ctrlE_resume got %h want 33", ctrlE); else passCnt++;
        checkCnt++; if (rd1E !== 32'h5) $display("[TB] FAIL lu_rd1E_resume got %h want 5", rd1E); else passCnt++;
        checkCnt++; if (rdE !== 5'd9) $display("[TB] FAIL lu_rdE_resume got %0d want 9", rdE); else passCnt++;
        checkCnt++; if (validE !== 1'b1) $display("[TB] FAIL lu_validE_resume got %b want 1", validE); else passCnt++;
    endtask

    task automatic test_jump();
        jumpD = 1; flushD = 1; jump_targetD = 32'h40; instrF = 32'hA000_0004;
        step();
        checkCnt++; if (pcF !== 32'h40) $display("[TB] FAIL jmp_pc got %h want 40", pcF); else passCnt++;
        checkCnt++; if (instrD !== 32'h0) $display("[TB] FAIL jmp_instrD got %h want 0", instrD); else passCnt++;
        checkCnt++; if (validD !== 1'b0) $display("[TB] FAIL jmp_validD got %b want 0", validD); else passCnt++;
        checkCnt++; if (pcplus4D !== 32'h0) $display("[TB] FAIL jmp_pc4D got %h want 0", pcplus4D); else passCnt++;
        jumpD = 0; flushD = 0; instrF = 32'hA000_0005; ctrlD = 8'h44;
        step();
        checkCnt++; if (validE !== 1'b0) $display("[TB] FAIL jmp_validE got %b want 0", validE); else passCnt++;
        checkCnt++; if (pcF !== 32'h44) $display("[TB] FAIL jmp_pc_next got %h want 44", pcF); else passCnt++;
        checkCnt++; if (instrD !== 32'hA000_0005) $display("[TB] FAIL jmp_instrD_next got %h want a0000005", instrD); else passCnt++;
    endtask

    task automatic test_branch_stall();
        stallF = 1; stallD = 1; pcsrcD = 1; branch_targetD = 32'h80;
        step();
        checkCnt++; if (pcF !== 32'h44) $display("[TB] FAIL br_pc_hold got %h want 44", pcF); else passCnt++;
        checkCnt++; if (instrD !== 32'hA000_0005) $display("[TB] FAIL br_instrD_hold got %h want a0000005", instrD); else passCnt++;
        checkCnt++; if (validD !== 1'b1) $display("[TB] FAIL br_validD_hold got %b want 1", validD); else passCnt++;
        stallF = 0; stallD = 0;
        step();
        checkCnt++; if (pcF !== 32'h80) $display("[TB] FAIL br_pc_taken got %h want 80", pcF); else passCnt++;
        checkCnt++; if (instrD !== 32'h0) $display("[TB] FAIL br_instrD_clr got %h want 0", instrD); else passCnt++;
        checkCnt++; if (validD !== 1'b0) $display("[TB] FAIL br_validD_clr got %b want 0", validD); else passCnt++;
        pcsrcD = 0;
    endtask

    task automatic test_wrap();
        jumpD = 1; flushD = 1; jump_targetD = 32'hFFFF_FFFC;
        step();
        checkCnt++; if (pcF !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_pc got %h want fffffffc", pcF); else passCnt++;
        checkCnt++; if (pcplus4F !== 32'h0) $display("[TB] FAIL wrap_pc4F got %h want 0", pcplus4F); else passCnt++;
        jumpD = 0; flushD = 0; instrF = 32'hA000_0006;
        step();
        checkCnt++; if (pcF !== 32'h0) $display("[TB] FAIL wrap_pc_next got %h want 0", pcF); else passCnt++;
        checkCnt++; if (validD !== 1'b1) $display("[TB] FAIL wrap_validD got %b want 1", validD); else passCnt++;
        checkCnt++; if (instrD !== 32'hA000_0006) $display("[TB] FAIL wrap_instrD got %h want a0000006", instrD); else passCnt++;
    endtask

    task automatic test_reset_mid_stall();
        jump_targetD = 32'h100; jumpD = 1; flushD = 1;
        step();
        jumpD = 0; flushD = 0; stallF = 1; stallD = 1;
        step();
        #2 rst = 1'b1;
        #1;
        checkCnt++; if (pcF !== 32'h0) $display("[TB] FAIL rststall_pc got %h want 0", pcF); else passCnt++;
        checkCnt++; if (validD !== 1'b0) $display("[TB] FAIL rststall_validD got %b want 0", validD); else passCnt++;
        stallF = 0; stallD = 0;
        step();
        rst = 1'b0;
        instrF = 32'hA000_0007;
        step();
        checkCnt++; if (validD !== 1'b1) $display("[TB] FAIL rststall_validD_rel got %b want 1", validD); else passCnt++;
        checkCnt++; if (pcF !== 32'h4) $display("[TB] FAIL rststall_pc_rel got %h want 4", pcF); else passCnt++;
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkCnt++; if (stall_cnt !== 32'h0) $display("[TB] FAIL perf_stall_rst got %0d want 0", stall_cnt); else passCnt++;
        checkCnt++; if (bubble_cnt !== 32'h0) $display("[TB] FAIL perf_bubble_rst got %0d want 0", bubble_cnt); else passCnt++;
        stallF = 1; stallD = 1;
        for (int i = 0; i < 5; i++) step();
        stallF = 0; stallD = 0; flushE = 1;
        for (int i = 0; i < 2; i++) step();
        flushE = 0;
        step();
        checkCnt++; if (stall_cnt !== 32'd5) $display("[TB] FAIL perf_stall got %0d want 5", stall_cnt); else passCnt++;
        checkCnt++; if (bubble_cnt !== 32'd2) $display("[TB] FAIL perf_bubble got %0d want 2", bubble_cnt); else passCnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_load_use();
        test_jump();
        test_branch_stall();
        test_wrap();
        test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
